operand_fetch: RTL and testbench

- Decode-to-execute operand stage, placed directly upstream of the 64-bit register file and feeding the execute stage.
- Drives register file read addresses from the incoming decoded instruction and captures the synchronous read data one cycle later.
- Patches that read data with same-edge and later writebacks, because the register file returns the pre-write value when a write and a read share a clock edge.
- Presents operands with a valid/ready handshake and supports a pipeline flush.

---
 rtl/operand_fetch_pkg.sv | 29 ++
 rtl/operand_fetch_bypass.sv | 26 ++
 rtl/operand_fetch.sv | 139 +++++++++++++
 tb/tb_operand_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: widths, register index type
// and the writeback-match helper used by the top and the bypass resolver.
package operand_fetch_pkg;

    localparam int XLEN      = 64;
    localparam int PC_W      = 64;
    localparam int CTRL_W    = 16;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    // Field offsets inside the opaque decoded-control bundle.
    localparam int CTRL_ALU_OP_LSB   = 0;
    localparam int CTRL_ALU_OP_W     = 4;
    localparam int CTRL_SRC2_IMM_BIT = 4;
    localparam int CTRL_MEM_RD_BIT   = 5;
    localparam int CTRL_MEM_WR_BIT   = 6;
    localparam int CTRL_BRANCH_BIT   = 7;
    localparam int CTRL_WB_EN_BIT    = 8;
    localparam int CTRL_FUNCT3_LSB   = 9;
    localparam int CTRL_FUNCT3_W     = 3;

    function automatic logic wb_hits(input logic en, input reg_idx_t rd, input reg_idx_t rs);
        return en && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/operand_fetch_bypass.sv
// Per-operand resolver: chooses between fresh register-file data, a captured
// same-edge bypass and the holding register, and computes the next held value.
module operand_bypass #(
    parameter int XLEN = 64
) (
    input  logic [4:0]      i_rs,
    input  logic            i_fresh,
    input  logic            i_hit,
    input  logic [XLEN-1:0] i_byp,
    input  logic [XLEN-1:0] i_rf_data,
    input  logic [XLEN-1:0] i_op_q,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_op,
    output logic [XLEN-1:0] o_op_next
);
    import operand_fetch_pkg::*;

    logic [XLEN-1:0] w_fresh_op;

    assign w_fresh_op = i_hit ? i_byp : i_rf_data;
    assign o_op       = i_fresh ? w_fresh_op : i_op_q;
    assign o_op_next  = wb_hits(i_wb_en, i_wb_rd, i_rs) ? i_wb_data : o_op;

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: drives register file reads, patches the
// registered read data with writebacks and holds operands across stalls.
module operand_fetch #(
    parameter int XLEN   = operand_fetch_pkg::XLEN,
    parameter int PC_W   = operand_fetch_pkg::PC_W,
    parameter int CTRL_W = operand_fetch_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_rs1,
    output logic [4:0]        rf_rs2,
    input  logic [XLEN-1:0]   rf_read_data1,
    input  logic [XLEN-1:0]   rf_read_data2,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [4:0]        out_rd,
    output logic [PC_W-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl
);
    import operand_fetch_pkg::*;

    logic              r_valid;
    logic              r_fresh;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [PC_W-1:0]   r_pc;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_hit1;
    logic              r_hit2;
    logic [XLEN-1:0]   r_byp1;
    logic [XLEN-1:0]   r_byp2;
    logic [XLEN-1:0]   r_op1_q;
    logic [XLEN-1:0]   r_op2_q;

    logic              w_accept;
    logic              w_stall;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic [XLEN-1:0]   w_op1_next;
    logic [XLEN-1:0]   w_op2_next;

    assign rf_rs1   = in_rs1;
    assign rf_rs2   = in_rs2;
    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_stall  = r_valid && !out_ready && !flush;

    operand_bypass #(.XLEN(XLEN)) u_byp1 (
        .i_rs      (r_rs1),
        .i_fresh   (r_fresh),
        .i_hit     (r_hit1),
        .i_byp     (r_byp1),
        .i_rf_data (rf_read_data1),
        .i_op_q    (r_op1_q),
        .i_wb_en   (wb_en),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data),
        .o_op      (w_op1),
        .o_op_next (w_op1_next)
    );

    operand_bypass #(.XLEN(XLEN)) u_byp2 (
        .i_rs      (r_rs2),
        .i_fresh   (r_fresh),
        .i_hit     (r_hit2),
        .i_byp     (r_byp2),
        .i_rf_data (rf_read_data2),
        .i_op_q    (r_op2_q),
        .i_wb_en   (wb_en),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data),
        .o_op      (w_op2),
        .o_op_next (w_op2_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_pc    <= '0;
            r_ctrl  <= '0;
            r_hit1  <= 1'b0;
            r_hit2  <= 1'b0;
            r_byp1  <= '0;
            r_byp2  <= '0;
            r_op1_q <= '0;
            r_op2_q <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
        end else if (w_accept) begin
            // The register file returns the pre-write value on a shared edge,
            // so a matching writeback on this edge is captured for bypass.
            r_valid <= 1'b1;
            r_fresh <= 1'b1;
            r_rs1   <= in_rs1;
            r_rs2   <= in_rs2;
            r_rd    <= in_rd;
            r_pc    <= in_pc;
            r_ctrl  <= in_ctrl;
            r_hit1  <= wb_hits(wb_en, wb_rd, in_rs1);
            r_hit2  <= wb_hits(wb_en, wb_rd, in_rs2);
            r_byp1  <= wb_data;
            r_byp2  <= wb_data;
        end else if (w_stall) begin
            r_op1_q <= w_op1_next;
            r_op2_q <= w_op2_next;
            r_fresh <= 1'b0;
        end else if (r_valid) begin
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_op1   = w_op1;
    assign out_op2   = w_op2;
    assign out_rd    = r_rd;
    assign out_pc    = r_pc;
    assign out_ctrl  = r_ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a registered register-file model feeds the
// DUT, and a handshake model predicts which instruction is presented.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [63:0] in_pc = '0;
    logic [15:0] in_ctrl = '0;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [63:0] rf_read_data1 = '0, rf_read_data2 = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic [63:0] out_pc;
    logic [15:0] out_ctrl;

    int total = 0;
    int bad   = 0;

    operand_fetch #(.XLEN(64), .PC_W(64), .CTRL_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_pc(out_pc), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    // Register file: synchronous read returning the pre-write value, x0 reads 0.
    logic [63:0] regs [32];

    always @(posedge clk) begin
        rf_read_data1 <= (rf_rs1 == 5'd0) ? 64'd0 : regs[rf_rs1];
        rf_read_data2 <= (rf_rs2 == 5'd0) ? 64'd0 : regs[rf_rs2];
        if (wb_en && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
    end

    function automatic logic [63:0] arch(input logic [4:0] r);
        return (r == 5'd0) ? 64'd0 : regs[r];
    endfunction

    // Presented instruction: its operands must always equal the current
    // architectural value of its source registers.
    logic        m_valid = 1'b0;
    logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [63:0] m_pc = '0;
    logic [15:0] m_ctrl = '0;
    logic        m_ready;
    logic        m_accept;

    assign m_ready  = !flush && (!m_valid || out_ready);
    assign m_accept = in_valid && m_ready;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (m_accept) begin
            m_valid <= 1'b1;
            m_rs1   <= in_rs1;
            m_rs2   <= in_rs2;
            m_rd    <= in_rd;
            m_pc    <= in_pc;
            m_ctrl  <= in_ctrl;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", 64'(in_ready), 64'(m_ready));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("rf_rs1", 64'(rf_rs1), 64'(in_rs1));
            chk("rf_rs2", 64'(rf_rs2), 64'(in_rs2));
            if (m_valid) begin
                chk("out_op1", out_op1, arch(m_rs1));
                chk("out_op2", out_op2, arch(m_rs2));
                chk("out_rd", 64'(out_rd), 64'(m_rd));
                chk("out_pc", out_pc, m_pc);
                chk("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
            end
        end else begin
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_op1", out_op1, 64'd0);
            chk("rst_op2", out_op2, 64'd0);
            chk("rst_pc", out_pc, 64'd0);
        end
    end

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [63:0] pc, input logic [15:0] ct,
                         input logic we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic rdy);
        in_valid = v; in_rs1 = a; in_rs2 = b; in_rd = d; in_pc = pc; in_ctrl = ct;
        wb_en = we; wb_rd = wr; wb_data = wd; out_ready = rdy; flush = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 16'd0, 1'b0, 5'd0, 64'd0, rdy);
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [4:0] b2b_rs [4];

    initial begin
        for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
        regs[5] <= 64'h1234;
        regs[9] <= 64'h5555;
        b2b_rs[0] = 5'd5; b2b_rs[1] = 5'd7; b2b_rs[2] = 5'd9; b2b_rs[3] = 5'd0;

        #1 reset_n = 1'b0;
        #1;
        chk("lit_reset_valid", 64'(out_valid), 64'd0);
        chk("lit_reset_op1", out_op1, 64'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Basic read.
        drive(1'b1, 5'd5, 5'd0, 5'd3, 64'h100, 16'h00A5, 1'b0, 5'd0, 64'd0, 1'b1);
        at_neg();
        chk("lit_basic_valid", 64'(out_valid), 64'd1);
        chk("lit_basic_op1", out_op1, 64'h1234);
        chk("lit_basic_op2", out_op2, 64'd0);

        // Same-edge bypass: register file still returns the old value.
        drive(1'b1, 5'd7, 5'd0, 5'd4, 64'h180, 16'h0011, 1'b1, 5'd7, 64'hDEAD, 1'b1);
        at_neg();
        chk("lit_bypass_op1", out_op1, 64'hDEAD);
        idle(1'b1);

        // Stall coherence and x0 guard during stall.
        drive(1'b1, 5'd5, 5'd9, 5'd12, 64'h200, 16'h003C, 1'b0, 5'd0, 64'd0, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 16'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        at_neg();
        chk("lit_stall1_op2", out_op2, 64'h5555);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 16'd0, 1'b1, 5'd9, 64'hBEEF, 1'b0);
        at_neg();
        chk("lit_stall2_op2", out_op2, 64'hBEEF);
        chk("lit_stall2_rd", 64'(out_rd), 64'd12);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 16'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        at_neg();
        chk("lit_stall3_op2", out_op2, 64'hBEEF);
        chk("lit_stall3_pc", out_pc, 64'h200);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 16'd0, 1'b1, 5'd0, 64'hFFFF, 1'b0);
        at_neg();
        chk("lit_x0stall_op1", out_op1, 64'h1234);
        chk("lit_x0stall_op2", out_op2, 64'hBEEF);
        idle(1'b1);
        at_neg();
        chk("lit_consumed", 64'(out_valid), 64'd0);

        // x0 guard at accept.
        drive(1'b1, 5'd0, 5'd5, 5'd1, 64'h280, 16'h0001, 1'b1, 5'd0, 64'hFFFF, 1'b1);
        at_neg();
        chk("lit_x0_op1", out_op1, 64'd0);
        chk("lit_x0_op2", out_op2, 64'h1234);

        // Back-to-back: four instructions on four consecutive edges.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, b2b_rs[i], b2b_rs[3-i], 5'(i + 1), 64'h300 + 64'(4 * i), 16'(i),
                  (i == 2), 5'd7, 64'h77, 1'b1);
            at_neg();
            chk("lit_b2b_valid", 64'(out_valid), 64'd1);
            chk("lit_b2b_pc", out_pc, 64'h300 + 64'(4 * i));
        end

        // Flush with a pending input and a stalled downstream.
        in_valid = 1'b1; in_rs1 = 5'd5; flush = 1'b1; out_ready = 1'b0; wb_en = 1'b0;
        #1;
        chk("lit_flush_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #2;
        flush = 1'b0; in_valid = 1'b0;
        at_neg();
        chk("lit_flush_valid", 64'(out_valid), 64'd0);
        idle(1'b1);
        at_neg();
        chk("lit_flush_none", 64'(out_valid), 64'd0);

        // Async reset mid-stall.
        drive(1'b1, 5'd5, 5'd9, 5'd6, 64'h400, 16'h0042, 1'b0, 5'd0, 64'd0, 1'b1);
        idle(1'b0);
        reset_n = 1'b0;
        #1;
        chk("lit_arst_valid", 64'(out_valid), 64'd0);
        chk("lit_arst_op1", out_op1, 64'd0);
        chk("lit_arst_pc", out_pc, 64'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        drive(1'b1, 5'd5, 5'd0, 5'd3, 64'h100, 16'h00A5, 1'b0, 5'd0, 64'd0, 1'b1);
        at_neg();
        chk("lit_post_valid", 64'(out_valid), 64'd1);
        chk("lit_post_op1", out_op1, 64'h1234);
        chk("lit_post_op2", out_op2, 64'd0);
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
